// File: rtl/gem_csc_lut_loader.sv
// Write-side sequencer for the GEM-CSC pad and roll lookup tables.
// Streams host words into the selected LUT and gates matching while loading.
module gem_csc_lut_loader #(
  parameter int MXXKYB   = 10,
  parameter int WIREBITS = 7,
  parameter int NPADS    = 192,
  parameter int NROLLS   = 8,
  parameter logic [MXXKYB-1:0] MINKEYHSME1B = 10'd0,
  parameter logic [MXXKYB-1:0] MAXKEYHSME1B = 10'd511,
  parameter logic [MXXKYB-1:0] MINKEYHSME1A = 10'd512,
  parameter logic [MXXKYB-1:0] MAXKEYHSME1A = 10'd895,
  parameter logic [WIREBITS-1:0] MAXWIRE    = 7'd47
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [2:0]        cfg_table,
  input  logic              cfg_abort,
  input  logic [MXXKYB-1:0] cfg_data,
  input  logic              cfg_data_vld,
  output logic              cfg_data_rdy,
  output logic              lut_wen,
  output logic [2:0]        lut_sel,
  output logic [7:0]        lut_w_adr,
  output logic [MXXKYB-1:0] lut_w_data,
  output logic              loading,
  output logic              done,
  output logic              aborted,
  output logic              range_err,
  output logic [7:0]        err_adr,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] PAD_LAST  = 8'(NPADS - 1);
  localparam logic [7:0] ROLL_LAST = 8'(NROLLS - 1);

  state_t r_state;
  state_t w_next;

  logic              r_wen;
  logic [2:0]        r_sel;
  logic [7:0]        r_adr;
  logic [MXXKYB-1:0] r_data;
  logic              r_done;
  logic              r_aborted;
  logic              r_range_err;
  logic [7:0]        r_err_adr;
  logic              r_cfg_err;
  logic [7:0]        r_cnt;
  logic [7:0]        r_last_adr;

  logic w_start_ok;
  logic w_start_bad;
  logic w_accept;
  logic w_abort;
  logic w_last;
  logic w_inrange;
  logic w_ok_me1a;
  logic w_ok_me1b;
  logic w_ok_roll;

  logic [MXXKYB:0] w_d_1a_lo;
  logic [MXXKYB:0] w_d_1a_hi;
  logic [MXXKYB:0] w_d_1b_lo;
  logic [MXXKYB:0] w_d_1b_hi;

  // Bound checks via widened subtraction: sign bit clear means in bound.
  assign w_d_1a_lo = {1'b0, cfg_data} - {1'b0, MINKEYHSME1A};
  assign w_d_1a_hi = {1'b0, MAXKEYHSME1A} - {1'b0, cfg_data};
  assign w_d_1b_lo = {1'b0, cfg_data} - {1'b0, MINKEYHSME1B};
  assign w_d_1b_hi = {1'b0, MAXKEYHSME1B} - {1'b0, cfg_data};

  assign w_ok_me1a = !w_d_1a_lo[MXXKYB] && !w_d_1a_hi[MXXKYB];
  assign w_ok_me1b = !w_d_1b_lo[MXXKYB] && !w_d_1b_hi[MXXKYB];
  assign w_ok_roll = (cfg_data[MXXKYB-1:WIREBITS] == '0) &&
                     (cfg_data[WIREBITS-1:0] <= MAXWIRE);

  always_comb begin
    w_inrange = 1'b0;
    unique case (1'b1)
      r_sel[2]:  w_inrange = w_ok_roll;
      r_sel[1]:  w_inrange = w_ok_me1b;
      default:   w_inrange = w_ok_me1a;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_start_ok  = cfg_start && (r_state == IDLE) &&
                  (cfg_table <= 3'd5);
    w_start_bad = cfg_start && (r_state == IDLE) &&
                  (cfg_table > 3'd5);
    w_abort     = cfg_abort && (r_state != IDLE);
    w_accept    = cfg_data_vld && (r_state == LOAD) && !cfg_abort;
    w_last      = (r_cnt == r_last_adr);
    unique case (r_state)
      IDLE: begin
        if (w_start_ok)
          w_next = LOAD;
      end
      LOAD: begin
        if (w_abort)
          w_next = IDLE;
        else if (w_accept && w_last)
          w_next = DRAIN;
      end
      DRAIN: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wen       <= 1'b0;
      r_sel       <= 3'd0;
      r_adr       <= 8'd0;
      r_data      <= '0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_range_err <= 1'b0;
      r_err_adr   <= 8'd0;
      r_cfg_err   <= 1'b0;
      r_cnt       <= 8'd0;
      r_last_adr  <= 8'd0;
    end else begin
      r_wen     <= w_accept;
      r_done    <= (r_state == DRAIN) && !cfg_abort;
      r_aborted <= w_abort;

      if (w_accept) begin
        r_adr  <= r_cnt;
        r_data <= cfg_data;
      end

      if (w_start_ok) begin
        r_sel       <= cfg_table;
        r_last_adr  <= cfg_table[2] ? ROLL_LAST : PAD_LAST;
        r_range_err <= 1'b0;
        r_err_adr   <= 8'd0;
        r_cfg_err   <= 1'b0;
      end else if (w_start_bad) begin
        r_cfg_err <= 1'b1;
      end

      // Counter stops on the last address; never wraps.
      if (w_start_ok || w_abort || (r_state == DRAIN))
        r_cnt <= 8'd0;
      else if (w_accept && !w_last)
        r_cnt <= r_cnt + 8'd1;

      if (w_accept && !w_inrange && !r_range_err) begin
        r_range_err <= 1'b1;
        r_err_adr   <= r_cnt;
      end
    end
  end

  assign cfg_data_rdy = (r_state == LOAD);
  assign loading      = (r_state != IDLE);
  assign lut_wen      = r_wen;
  assign lut_sel      = r_sel;
  assign lut_w_adr    = r_adr;
  assign lut_w_data   = r_data;
  assign done         = r_done;
  assign aborted      = r_aborted;
  assign range_err    = r_range_err;
  assign err_adr      = r_err_adr;
  assign cfg_err      = r_cfg_err;

endmodule
